// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    localparam int EVENT_W = $bits(ps2_event_t);

    // PS/2 uses odd parity over the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO with a combinational head; a push when full is accepted only alongside a pop.
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == FULL_LVL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; the level/pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: sync, glitch filter, frame FSM with timeout, prefix decoder, event FIFO.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int DECODE         = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_code,
    output logic                          out_ext,
    output logic                          out_brk,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          err_clear
);

    localparam int FL_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]      clk_sync;
    logic [1:0]      data_sync;
    logic [FL_W-1:0] filt_cnt;
    logic            clk_filt;
    logic            clk_filt_q;
    logic            fall;

    rx_state_t       state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            par_bit;
    logic [TO_W-1:0] to_cnt;
    logic            pend_ext;
    logic            pend_brk;

    logic            frame_end;
    logic            par_ok;
    logic            byte_good;
    logic            is_prefix;
    logic            timeout;
    logic            push;
    logic            drop;
    logic            empty;
    logic            full;
    ps2_event_t      push_evt;
    ps2_event_t      head_evt;

    // Lines idle high, so the synchronisers reset to 1 to avoid a phantom edge after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            filt_cnt   <= '0;
            clk_filt   <= 1'b1;
            clk_filt_q <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            data_sync  <= {data_sync[0], ps2_data};
            clk_filt_q <= clk_filt;
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FL_W'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall      = clk_filt_q && !clk_filt;
    assign frame_end = fall && (state == STOP);
    assign par_ok    = odd_parity_ok(shift, par_bit);
    assign byte_good = frame_end && data_sync[1] && par_ok;
    assign is_prefix = (DECODE != 0) && ((shift == PS2_EXT) || (shift == PS2_BRK));
    assign push      = byte_good && !is_prefix;
    assign timeout   = (state != IDLE) && !fall && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign push_evt  = '{ext: pend_ext, brk: pend_brk, code: shift};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            pend_ext   <= 1'b0;
            pend_brk   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (fall || state == IDLE || timeout) to_cnt <= '0;
            else                                  to_cnt <= to_cnt + 1'b1;

            if (timeout) begin
                state    <= IDLE;
                pend_ext <= 1'b0;
                pend_brk <= 1'b0;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!data_sync[1]) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift   <= {data_sync[1], shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= data_sync[1];
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (byte_good && DECODE != 0 && shift == PS2_EXT) begin
                            pend_ext <= 1'b1;
                        end else if (byte_good && DECODE != 0 && shift == PS2_BRK) begin
                            pend_brk <= 1'b1;
                        end else begin
                            pend_ext <= 1'b0;
                            pend_brk <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            // A new error in the same cycle as err_clear must survive the clear.
            parity_err <= (frame_end && !par_ok) || (parity_err && !err_clear);
            frame_err  <= (frame_end && !data_sync[1]) || timeout || (frame_err && !err_clear);
            overflow   <= drop || (overflow && !err_clear);
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_evt),
        .pop       (out_valid && out_ready),
        .head      (head_evt),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level),
        .drop      (drop)
    );

    assign out_valid = !empty;
    assign out_code  = head_evt.code;
    assign out_ext   = head_evt.ext;
    assign out_brk   = head_evt.brk;

endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

Parametrised PS/2 device-to-host receiver with a noise filter, frame timeout, error reporting, optional make/break/extended-prefix decoding and a configurable-depth event FIFO. It sits between the board's PS/2 pins and any consumer such as the keyboard display logic or a CPU MMIO register. Events are delivered on a valid/ready handshake.

## Interface
- FIFO_DEPTH, 8: event FIFO entries; power of two, ≥2
- FILTER_LEN, 4: consecutive clk cycles the synchronised ps2_clk must hold a new level before it is accepted; ≥1
- TIMEOUT_CYCLES, 50000: max clk cycles between falling edges inside a frame; ≥16
- DECODE, 1: 1 = fold E0/F0 prefixes into flags; 0 = raw byte stream
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- ps2_clk  in  1  asynchronous PS/2 clock pin
- ps2_data  in  1  asynchronous PS/2 data pin
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head entry
- out_code  out  8  head scancode byte
- out_ext  out  1  head entry was preceded by E0
- out_brk  out  1  head entry was preceded by F0 (key release)
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
- parity_err  out  1  sticky: frame with bad parity seen
- frame_err  out  1  sticky: bad stop bit or timeout
- overflow  out  1  sticky: event dropped, FIFO full
- err_clear  in  1  clears all three sticky flags

## Operation
- ps2_clk and ps2_data each pass through a 2-FF synchroniser. The filtered clock level is reset to 1 and changes only after FILTER_LEN stable cycles. A falling edge is a filtered 1→0 transition.
- The receive FSM has four states:
  - IDLE: on a falling edge, if synced data is 0 (start bit), go to DATA with bit count 0; otherwise stay in IDLE (the edge is ignored).
  - DATA: shift in 8 bits, LSB first; after the 8th bit go to PARITY.
  - PARITY: capture the bit, then go to STOP.
  - STOP: check that stop = 1 and that odd parity holds over data+parity, then return to IDLE.
- Frame errors:
  - Bad parity sets parity_err and drops the byte.
  - Stop bit 0 sets frame_err and drops the byte.
  - Both failing sets both flags.
- Timeout: a counter clears on every falling edge and increments while the FSM is not in IDLE. Reaching TIMEOUT_CYCLES forces IDLE, sets frame_err, and discards the partial byte.
- Decoder with DECODE=1:
  - Byte E0 sets pend_ext; byte F0 sets pend_brk. No push occurs for either.
  - Any other byte pushes {pend_ext, pend_brk, byte} and clears both pending flags.
  - Any frame error or timeout also clears both pending flags.
- Decoder with DECODE=0: every good byte is pushed with ext=brk=0.
- FIFO behaviour:
  - Entries are 10 bits wide. The head is presented combinationally from the read pointer.
  - A pop occurs when out_valid && out_ready.
  - A push when full is dropped and sets overflow, unless a pop happens in the same cycle; in that case the push is accepted and the level is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: err_clear clears all three. If a set and err_clear occur in the same cycle, the set wins.
- Reset values:
  - Outputs: out_valid=0, fifo_level=0, all sticky flags 0. out_code, out_ext and out_brk are don't-care while out_valid=0.
  - Internal state: FSM in IDLE, pending flags 0, FIFO emptied.
- Reset mid-frame discards the frame; reception restarts cleanly at the next start bit.

## Timing
- Pin edge to filtered edge takes 2 + FILTER_LEN clk edges. The FSM acts on the next edge.
- Stop-bit falling edge at the pin to out_valid=1 takes FILTER_LEN+3 clk edges, given an empty FIFO.
- Pop takes effect at the handshake clock edge. The next entry (or out_valid=0) is visible in the following cycle.
- Throughput is one pop per cycle; the receive rate is bounded by the PS/2 line at ≤1 byte per ~11 ps2_clk periods.
- fifo_level is updated at the same edge as the push/pop.

## Structure
- A shared package ps2_pkg holds:
  - the state enum for the FSM (IDLE, DATA, PARITY, STOP);
  - the constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0;
  - the event typedef {ext, brk, code[7:0]}.
- One sub-module, ps2_event_fifo, is parametrised by depth and width. It provides push/pop, full/empty, level and the simultaneous push-on-full rule.
- The synchroniser, filter, FSM, timeout and decoder live in the top module.

## Test plan
- Send frame 0x1C with good parity, keep out_ready=0 → out_valid rises FILTER_LEN+3 cycles after the stop edge; out_code=1C, ext=0, brk=0, fifo_level=1.
- Send E0 F0 75 with DECODE=1 → exactly one entry: code=75, ext=1, brk=1. With DECODE=0 → three entries E0, F0, 75, all with flags 0.
- Send 0x1C with parity flipped, then 0x32 good → parity_err=1 and only 32 is queued. Pulse err_clear → parity_err=0.
- Send a start bit and 3 data bits, then hold ps2_clk high for TIMEOUT_CYCLES → frame_err=1, FSM in IDLE, no push. A following good frame 0x1C is received correctly.
- Keep out_ready=0 and send FIFO_DEPTH+1 bytes → fifo_level=FIFO_DEPTH, overflow=1, and the head is the first byte. Then drain with out_ready=1 → bytes come out in order and the last one is lost.
- Inject glitches on ps2_clk shorter than FILTER_LEN cycles during a frame → the received byte is unaffected. Assert rst_n=0 mid-frame → all outputs return to reset values and the next frame is received intact.
